// File: rtl/add_arbiter_if.sv
// add_arbiter_if: request/response bus shared by two adder requesters and one result consumer
interface add_arbiter_if #(parameter int DATA_WID = 32);
    logic                    req0_valid;
    logic                    req1_valid;
    logic                    req0_ready;
    logic                    req1_ready;
    logic [2*DATA_WID-1:0]   req0_a;
    logic [2*DATA_WID-1:0]   req0_b;
    logic [2*DATA_WID-1:0]   req1_a;
    logic [2*DATA_WID-1:0]   req1_b;
    logic                    req0_cin;
    logic                    req1_cin;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic                    rsp_id;
    logic [2*DATA_WID-1:0]   rsp_sum;
    logic                    rsp_cout;
    logic                    busy;

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_cin, req1_cin, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
    );

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_cin, req1_cin, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
    );
endinterface

// File: rtl/add_arbiter.sv
// add_arbiter: two-requester round-robin front end sharing one CLA over two half-width passes

// cla32bit: WID-bit carry-lookahead adder built from 4-bit lookahead groups (WID must be a multiple of 4)
module cla32bit #(parameter int WID = 32) (
    input  logic [WID-1:0] a,
    input  logic [WID-1:0] b,
    input  logic           cin,
    output logic [WID-1:0] sum,
    output logic           cout
);
    logic [WID-1:0] g;
    logic [WID-1:0] p;
    logic [3:0]     gg;
    logic [3:0]     pp;
    logic [3:0]     cc;
    logic           c;

    assign g = a & b;
    assign p = a ^ b;

    // each group resolves its internal carries from generate/propagate, group carry chains to the next
    always_comb begin
        c   = cin;
        sum = '0;
        gg  = '0;
        pp  = '0;
        cc  = '0;
        for (int k = 0; k < WID / 4; k++) begin
            gg = g[4*k +: 4];
            pp = p[4*k +: 4];
            cc[0] = c;
            cc[1] = gg[0] | (pp[0] & c);
            cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c);
            cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) | (pp[2] & pp[1] & pp[0] & c);
            sum[4*k +: 4] = pp ^ cc;
            c = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) | (pp[3] & pp[2] & pp[1] & gg[0]) | ((&pp) & c);
        end
        cout = c;
    end
endmodule

module add_arbiter #(parameter int DATA_WID = 32) (
    input  logic         clk,
    input  logic         rst_n,
    add_arbiter_if.slave bus
);
    localparam int W = DATA_WID;

    typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

    state_t         state;
    logic           last;
    logic           gnt_id;
    logic           any_valid;
    logic           carry;
    logic [2*W-1:0] a_q;
    logic [2*W-1:0] b_q;
    logic           cin_q;
    logic [2*W-1:0] sum_q;
    logic           cout_q;
    logic           id_q;
    logic           valid_q;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic [W-1:0]   add_sum;
    logic           add_cin;
    logic           add_cout;

    // contention goes to the requester not granted last; a lone valid always wins
    assign any_valid = bus.req0_valid | bus.req1_valid;
    assign gnt_id    = (bus.req0_valid & bus.req1_valid) ? ~last : bus.req1_valid;

    // readys are combinational and forced low while reset is asserted
    assign bus.req0_ready = rst_n & (state == IDLE) & bus.req0_valid & ~gnt_id;
    assign bus.req1_ready = rst_n & (state == IDLE) & bus.req1_valid & gnt_id;

    // the single adder sees the low halves in LO and the high halves plus the LO carry otherwise
    assign add_a   = (state == HI) ? a_q[2*W-1:W] : a_q[W-1:0];
    assign add_b   = (state == HI) ? b_q[2*W-1:W] : b_q[W-1:0];
    assign add_cin = (state == HI) ? carry : cin_q;

    cla32bit #(.WID(W)) u_cla (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // control FSM: grant and latch in IDLE, two adder passes, then hold the result until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            last    <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            carry   <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            id_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (any_valid) begin
                    a_q   <= gnt_id ? bus.req1_a : bus.req0_a;
                    b_q   <= gnt_id ? bus.req1_b : bus.req0_b;
                    cin_q <= gnt_id ? bus.req1_cin : bus.req0_cin;
                    id_q  <= gnt_id;
                    last  <= gnt_id;
                    state <= LO;
                end
                LO: begin
                    sum_q[W-1:0] <= add_sum;
                    carry        <= add_cout;
                    state        <= HI;
                end
                HI: begin
                    sum_q[2*W-1:W] <= add_sum;
                    cout_q         <= add_cout;
                    valid_q        <= 1'b1;
                    state          <= RESP;
                end
                RESP: if (bus.rsp_ready) begin
                    valid_q <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = valid_q;
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_cout  = cout_q;
    assign bus.rsp_id    = id_q;
    assign bus.busy      = (state != IDLE);
endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WID, default 32, the width of one adder pass; operands and results are 2*DATA_WID bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-004 The block SHALL have ports req0_valid/req1_valid, input, 1 each, signalling that requester n presents an add.
REQ-005 The block SHALL have ports req0_ready/req1_ready, output, 1 each, signalling acceptance of requester n's operands this cycle.
REQ-006 The block SHALL have ports req0_a/req0_b and req1_a/req1_b, input, 2*DATA_WID each, the operands.
REQ-007 The block SHALL have ports req0_cin/req1_cin, input, 1 each, the carry-in.
REQ-008 The block SHALL have port rsp_valid, output, 1, signalling that a result is presented.
REQ-009 The block SHALL have port rsp_ready, input, 1, signalling that the consumer accepts the result.
REQ-010 The block SHALL have ports rsp_id (output, 1, index of the served requester), rsp_sum (output, 2*DATA_WID, the sum) and rsp_cout (output, 1, the carry-out).
REQ-011 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-012 All additions SHALL use exactly one instance of the team's DATA_WID-bit carry-lookahead adder (cla32bit), time-shared across both requesters and both halves.
REQ-013 The FSM SHALL have the states IDLE, LO, HI and RESP.
REQ-014 In IDLE with at least one valid, the block SHALL grant one requester, assert only that requester's ready combinationally, latch its a, b, cin and id, and go to LO.
REQ-015 Arbitration SHALL be round-robin: with both valid, the requester not granted last wins; with one valid, that requester wins.
REQ-016 The last-grant pointer SHALL update only on a grant.
REQ-017 In LO, the adder SHALL compute a[DATA_WID-1:0]+b[DATA_WID-1:0]+cin; the sum is registered into rsp_sum low half, the carry into an internal register; next state HI.
REQ-018 In HI, the adder SHALL compute the upper halves plus the LO carry; the sum is registered into rsp_sum high half and the carry into rsp_cout; next state RESP.
REQ-019 In RESP, rsp_valid SHALL be 1 and rsp_sum, rsp_cout and rsp_id SHALL be held stable until rsp_ready is sampled high; the block then goes to IDLE and drops rsp_valid in the following cycle.
REQ-020 Latency SHALL be 3 cycles: a handshake at edge T gives rsp_valid high after edge T+2 (visible in cycle T+3); the minimum issue interval is 4 cycles.
REQ-021 Outside IDLE, both readys SHALL be 0; a requester dropping valid before a handshake SHALL have no effect.
REQ-022 Results SHALL be exact modulo 2^(2*DATA_WID), with rsp_cout as bit 2*DATA_WID of the true sum; all-ones + 0 + cin=1 wraps to 0 with cout=1.
REQ-023 Operand changes on the request ports after the handshake SHALL NOT affect the result in flight.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, busy=0, both readys=0 and the internal carry to 0, and set last-grant to 1 so that requester 0 wins the first contention.
REQ-025 Reset mid-operation SHALL discard the in-flight add with no response issued; operation SHALL resume on the first clk edge after rst_n rises.

Verification
REQ-026 Scenario (single add): req0 valid, a=0x00000000_FFFFFFFF, b=1, cin=0 -> req0_ready in that cycle, rsp_valid 3 cycles later, rsp_sum=0x00000001_00000000, cout=0, id=0.
REQ-027 Scenario (full wrap): req1 valid, a=b=0xFFFFFFFF_FFFFFFFF, cin=1 -> rsp_sum=0xFFFFFFFF_FFFFFFFF, cout=1, id=1.
REQ-028 Scenario (contention): both valid continuously after reset -> grants in the order 0,1,0,1 with responses ids matching and no grant while busy.
REQ-029 Scenario (backpressure): rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and data stable for all 5 cycles, no new ready, and the result is accepted on the first rsp_ready=1.
REQ-030 Scenario (reset mid-op): rst_n pulsed low during HI -> outputs zero asynchronously, no rsp_valid, and a subsequent req0 add of 2+3 returns 5.
REQ-031 Scenario (random): 10k random operands and carry-ins across both requesters with random rsp_ready -> every response equals {cout,sum} = a+b+cin with the correct id.
